// File: rtl/s011hd1p_sram_bwm.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// s011hd1p_sram_bwm
//
// Behavioural single-port SRAM. It stands in for the tag and data arrays of
// the cache and TLB blocks in simulation. It has:
//   - configurable width, depth and read latency (1 or 2 cycles),
//   - an active-low per-bit write mask,
//   - a read-valid strobe,
//   - a clear sequencer that writes INIT_VAL to every word after reset.
//
// Ports
//   CLK        clock; all logic is on the rising edge
//   RST        synchronous reset, active-high
//   CEB        chip enable, active-low
//   WEB        write enable, active-low (1 = read)
//   BWEB       bit-write mask, active-low (0 = write this bit)
//   A          word address
//   D          write data
//   Q          read data; it holds the last read value while QVLD is low
//   QVLD       Q carries a fresh read result this cycle
//   INIT_DONE  the clear sequence has finished and the array accepts accesses
//
// Handshake: the array has no back-pressure. Every access presented with
// CEB=0 while INIT_DONE=1 is accepted at that rising edge. A read returns
// exactly one QVLD pulse RD_LAT cycles later, and results come back in issue
// order. Accesses presented while INIT_DONE=0 are dropped without a response.
// ---------------------------------------------------------------------------
module s011hd1p_sram_bwm #(
  parameter int              Bits       = 20,
  parameter int              Word_Depth = 128,
  parameter int              Add_Width  = 7,
  parameter int              RD_LAT     = 1,
  parameter logic [Bits-1:0] INIT_VAL   = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CEB,
  input  logic                 WEB,
  input  logic [Bits-1:0]      BWEB,
  input  logic [Add_Width-1:0] A,
  input  logic [Bits-1:0]      D,
  output logic [Bits-1:0]      Q,
  output logic                 QVLD,
  output logic                 INIT_DONE
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // The depth is widened by one bit, so Word_Depth == 2**Add_Width still
  // fits in the range compare.
  localparam logic [Add_Width:0]   DEPTH_W  = (Add_Width+1)'(Word_Depth);
  localparam logic [Add_Width-1:0] LAST_IDX = Add_Width'(Word_Depth - 1);

  logic [Bits-1:0] mem [Word_Depth];

  state_t               state_q, state_d;
  logic [Add_Width-1:0] cnt_q, cnt_d;

  logic            in_range;
  logic            init_wr;
  logic            acc_wr;
  logic            acc_rd;
  logic [Bits-1:0] rd_word;
  logic [Bits-1:0] wr_word;

  assign in_range  = ({1'b0, A} < DEPTH_W);
  assign INIT_DONE = (state_q == ST_READY);

  // Out-of-range reads return zero instead of whatever the model holds.
  assign rd_word = in_range ? mem[A] : '0;

  // Masked merge: bits whose BWEB is 0 take D; the other bits keep the stored value.
  assign wr_word = (rd_word & BWEB) | (D & ~BWEB);

  // -------------------------------------------------------------------------
  // Sequencer: the state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer: next state and access decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_wr = 1'b0;
    acc_wr  = 1'b0;
    acc_rd  = 1'b0;
    case (state_q)
      ST_INIT: begin
        // The port is ignored during the clear. One word is written per cycle.
        init_wr = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (!CEB) begin
          if (!WEB) begin
            // Writes to addresses past the end are dropped.
            acc_wr = in_range;
          end else begin
            acc_rd = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // -------------------------------------------------------------------------
  // Array: RST does not clear the storage itself. The clear sequencer
  // initialises every word once reset is released.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (init_wr) begin
        mem[cnt_q] <= INIT_VAL;
      end else if (acc_wr) begin
        mem[A] <= wr_word;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read pipeline
  // -------------------------------------------------------------------------
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [Bits-1:0] s1_data;
      logic            s1_vld;

      // Reset flushes a read that is still in the first stage.
      always_ff @(posedge CLK) begin
        if (RST) begin
          s1_data <= '0;
          s1_vld  <= 1'b0;
          Q       <= '0;
          QVLD    <= 1'b0;
        end else begin
          s1_vld <= acc_rd;
          if (acc_rd) begin
            s1_data <= rd_word;
          end
          QVLD <= s1_vld;
          if (s1_vld) begin
            Q <= s1_data;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge CLK) begin
        if (RST) begin
          Q    <= '0;
          QVLD <= 1'b0;
        end else begin
          QVLD <= acc_rd;
          if (acc_rd) begin
            Q <= rd_word;
          end
        end
      end
    end
  endgenerate

endmodule
